bus_txn_sequencer: RTL and testbench



---
 rtl/bus_txn_sequencer.sv | 216 +++++++++++++++++++++
 tb/tb_bus_txn_sequencer.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/bus_txn_sequencer.sv
// bus_txn_sequencer: runs one CPU bus cycle against internal RAM/ROM, the LED register or an AXI4-Lite slave
module bus_txn_sequencer #(
   parameter int RAM_AW         = 16,
   parameter int ROM_AW         = 12,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req,
   input  logic              is_read,
   input  logic [2:0]        addr_type,
   input  logic [31:0]       A32,
   input  logic [31:0]       D32,
   input  logic [3:0]        wstrb,
   input  logic [7:0]        cpu_wdata,
   output logic              ack,
   output logic [7:0]        rdata,
   output logic              err,
   output logic              ram_en,
   output logic              ram_we,
   output logic [RAM_AW-1:0] ram_addr,
   output logic [7:0]        ram_wdata,
   input  logic [7:0]        ram_rdata,
   output logic              rom_en,
   output logic [ROM_AW-1:0] rom_addr,
   input  logic [7:0]        rom_rdata,
   output logic [7:0]        led,
   output logic [31:0]       awaddr,
   output logic              awvalid,
   input  logic              awready,
   output logic [31:0]       wdata,
   output logic [3:0]        wstrb_o,
   output logic              wvalid,
   input  logic              wready,
   input  logic [1:0]        bresp,
   input  logic              bvalid,
   output logic              bready,
   output logic [31:0]       araddr,
   output logic              arvalid,
   input  logic              arready,
   input  logic [31:0]       rdata_axi,
   input  logic [1:0]        rresp,
   input  logic              rvalid,
   output logic              rready
);
   localparam logic [2:0] ADDR_TYPE_NOT_OP       = 3'd0;
   localparam logic [2:0] ADDR_TYPE_INTERNAL_RAM = 3'd1;
   localparam logic [2:0] ADDR_TYPE_INTERNAL_ROM = 3'd2;
   localparam logic [2:0] ADDR_TYPE_INTERNAL_LED = 3'd3;
   localparam logic [2:0] ADDR_TYPE_AXI          = 3'd4;
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   typedef enum logic [2:0] {S_IDLE, S_INT, S_AXI_WR, S_AXI_B, S_AXI_AR, S_AXI_R, S_DONE} state_t;
   state_t state_q, state_d;
   logic [2:0] type_q, type_d;
   logic is_read_q, is_read_d, ack_q, ack_d, err_q, err_d;
   logic [31:0] a32_q, a32_d, wdata_q, wdata_d;
   logic [3:0] wstrb_o_q, wstrb_o_d;
   logic [7:0] wd_q, wd_d, rdata_q, rdata_d, led_q, led_d;
   logic awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
   logic arvalid_q, arvalid_d, rready_q, rready_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic is_int, in_axi;
   assign is_int = (type_q == ADDR_TYPE_INTERNAL_RAM) || (type_q == ADDR_TYPE_INTERNAL_ROM);
   assign in_axi = (state_q == S_AXI_WR) || (state_q == S_AXI_B) || (state_q == S_AXI_AR) || (state_q == S_AXI_R);
   // Next-state and registered-output computation for the whole transaction
   always_comb begin
      state_d   = state_q;
      type_d    = type_q;
      is_read_d = is_read_q;
      a32_d     = a32_q;
      wd_d      = wd_q;
      wdata_d   = wdata_q;
      wstrb_o_d = wstrb_o_q;
      ack_d     = ack_q;
      err_d     = err_q;
      rdata_d   = rdata_q;
      led_d     = led_q;
      awvalid_d = awvalid_q;
      wvalid_d  = wvalid_q;
      bready_d  = bready_q;
      arvalid_d = arvalid_q;
      rready_d  = rready_q;
      cnt_d     = in_axi ? cnt_q + CW'(1) : '0;
      case (state_q)
         S_IDLE: if (req && addr_type != ADDR_TYPE_NOT_OP) begin
            type_d    = addr_type;
            is_read_d = is_read;
            a32_d     = A32;
            wd_d      = cpu_wdata;
            wdata_d   = (wstrb != 4'd0) ? D32 : {4{cpu_wdata}};
            wstrb_o_d = (wstrb != 4'd0) ? wstrb : 4'b0001 << A32[1:0];
            err_d     = 1'b0;
            case (addr_type)
               ADDR_TYPE_INTERNAL_RAM, ADDR_TYPE_INTERNAL_ROM: state_d = S_INT;
               ADDR_TYPE_INTERNAL_LED: begin
                  rdata_d = is_read ? led_q : rdata_q;
                  led_d   = is_read ? led_q : cpu_wdata;
                  state_d = S_DONE;
               end
               ADDR_TYPE_AXI: begin
                  arvalid_d = is_read;
                  awvalid_d = !is_read;
                  wvalid_d  = !is_read;
                  state_d   = is_read ? S_AXI_AR : S_AXI_WR;
               end
               default: begin
                  rdata_d = 8'hFF;
                  state_d = S_DONE;
               end
            endcase
         end
         S_INT: state_d = S_DONE;
         S_AXI_WR: begin
            awvalid_d = awvalid_q && !awready;
            wvalid_d  = wvalid_q && !wready;
            if (!awvalid_d && !wvalid_d) begin
               bready_d = 1'b1;
               state_d  = S_AXI_B;
            end
         end
         S_AXI_B: if (bvalid) begin
            err_d    = bresp != 2'd0;
            bready_d = 1'b0;
            state_d  = S_DONE;
         end
         S_AXI_AR: if (arready) begin
            arvalid_d = 1'b0;
            rready_d  = 1'b1;
            state_d   = S_AXI_R;
         end
         S_AXI_R: if (rvalid) begin
            rdata_d  = rdata_axi[8*a32_q[1:0] +: 8];
            err_d    = rresp != 2'd0;
            rready_d = 1'b0;
            state_d  = S_DONE;
         end
         S_DONE: if (!ack_q) begin
            ack_d   = 1'b1;
            rdata_d = (is_int && is_read_q) ? ((type_q == ADDR_TYPE_INTERNAL_ROM) ? rom_rdata : ram_rdata) : rdata_q;
         end else if (!req) begin
            ack_d   = 1'b0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      if (in_axi && state_d != S_DONE && cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
         awvalid_d = 1'b0;
         wvalid_d  = 1'b0;
         bready_d  = 1'b0;
         arvalid_d = 1'b0;
         rready_d  = 1'b0;
         rdata_d   = 8'hFF;
         err_d     = 1'b1;
         state_d   = S_DONE;
      end
   end
   // State and output registers; reset abandons any transaction in flight
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         type_q    <= ADDR_TYPE_NOT_OP;
         is_read_q <= 1'b0;
         a32_q     <= '0;
         wd_q      <= '0;
         wdata_q   <= '0;
         wstrb_o_q <= '0;
         ack_q     <= 1'b0;
         err_q     <= 1'b0;
         rdata_q   <= '0;
         led_q     <= '0;
         awvalid_q <= 1'b0;
         wvalid_q  <= 1'b0;
         bready_q  <= 1'b0;
         arvalid_q <= 1'b0;
         rready_q  <= 1'b0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         type_q    <= type_d;
         is_read_q <= is_read_d;
         a32_q     <= a32_d;
         wd_q      <= wd_d;
         wdata_q   <= wdata_d;
         wstrb_o_q <= wstrb_o_d;
         ack_q     <= ack_d;
         err_q     <= err_d;
         rdata_q   <= rdata_d;
         led_q     <= led_d;
         awvalid_q <= awvalid_d;
         wvalid_q  <= wvalid_d;
         bready_q  <= bready_d;
         arvalid_q <= arvalid_d;
         rready_q  <= rready_d;
         cnt_q     <= cnt_d;
      end
   end
   assign ram_en    = (state_q == S_INT) && (type_q == ADDR_TYPE_INTERNAL_RAM);
   assign ram_we    = ram_en && !is_read_q;
   assign rom_en    = (state_q == S_INT) && (type_q == ADDR_TYPE_INTERNAL_ROM);
   assign ram_addr  = a32_q[RAM_AW-1:0];
   assign rom_addr  = a32_q[ROM_AW-1:0];
   assign ram_wdata = wd_q;
   assign ack       = ack_q;
   assign err       = err_q;
   assign rdata     = rdata_q;
   assign led       = led_q;
   assign awaddr    = a32_q;
   assign araddr    = a32_q;
   assign wdata     = wdata_q;
   assign wstrb_o   = wstrb_o_q;
   assign awvalid   = awvalid_q;
   assign wvalid    = wvalid_q;
   assign bready    = bready_q;
   assign arvalid   = arvalid_q;
   assign rready    = rready_q;
endmodule

// File: tb/tb_bus_txn_sequencer.sv
// tb_bus_txn_sequencer: directed checks of the bus transaction sequencer
module tb_bus_txn_sequencer;
   localparam int T = 1024;
   localparam logic [2:0] AT_NOP = 3'd0, AT_RAM = 3'd1, AT_ROM = 3'd2, AT_LED = 3'd3, AT_AXI = 3'd4, AT_UNK = 3'd5;
   localparam logic [31:0] UART_TX = 32'h1000_0000;
   logic clk = 1'b0, rst = 1'b1, req = 1'b0, is_read = 1'b0;
   logic [2:0] addr_type = '0;
   logic [31:0] A32 = '0, D32 = '0, rdata_axi = '0;
   logic [3:0] wstrb = '0, wstrb_o;
   logic [7:0] cpu_wdata = '0, rdata, ram_wdata, ram_rdata = '0, rom_rdata = '0, led;
   logic ack, err, ram_en, ram_we, rom_en;
   logic [15:0] ram_addr;
   logic [11:0] rom_addr;
   logic [31:0] awaddr, wdata, araddr;
   logic awvalid, wvalid, bready, arvalid, rready;
   logic awready = 1'b0, wready = 1'b0, bvalid = 1'b0, arready = 1'b0, rvalid = 1'b0;
   logic [1:0] bresp = '0, rresp = '0;
   logic [7:0] mem [0:65535];
   int n_cmp = 0, n_bad = 0, aw_hs = 0, w_hs = 0, n;
   bus_txn_sequencer dut (
      .clk(clk), .rst(rst), .req(req), .is_read(is_read), .addr_type(addr_type), .A32(A32), .D32(D32),
      .wstrb(wstrb), .cpu_wdata(cpu_wdata), .ack(ack), .rdata(rdata), .err(err),
      .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
      .rom_en(rom_en), .rom_addr(rom_addr), .rom_rdata(rom_rdata), .led(led),
      .awaddr(awaddr), .awvalid(awvalid), .awready(awready), .wdata(wdata), .wstrb_o(wstrb_o),
      .wvalid(wvalid), .wready(wready), .bresp(bresp), .bvalid(bvalid), .bready(bready),
      .araddr(araddr), .arvalid(arvalid), .arready(arready), .rdata_axi(rdata_axi), .rresp(rresp),
      .rvalid(rvalid), .rready(rready)
   );
   always #5 clk = ~clk;
   // Memory models with one cycle of read latency, plus AXI handshake counters
   always @(posedge clk) begin
      if (ram_en) begin
         if (ram_we) mem[ram_addr] <= ram_wdata;
         ram_rdata <= mem[ram_addr];
      end
      if (rom_en) rom_rdata <= rom_addr[7:0] ^ 8'hA5;
      if (awvalid && awready) aw_hs <= aw_hs + 1;
      if (wvalid && wready) w_hs <= w_hs + 1;
   end
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic start(input logic [2:0] t, input logic rd, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input logic [7:0] w);
      addr_type = t; is_read = rd; A32 = a; D32 = d; wstrb = s; cpu_wdata = w; req = 1'b1;
      tick();
   endtask
   task automatic finish_txn();
      req = 1'b0;
      tick();
      check("ack_drop", ack, 0);
   endtask
   task automatic int_txn(input string tag, input logic [2:0] t, input logic rd, input logic [31:0] a,
                          input logic [7:0] w, input logic [7:0] exp);
      start(t, rd, a, 0, 0, w);
      check({tag, "_en_E0"}, {ram_en, ram_we, rom_en}, (t == AT_RAM) ? {2'b10 | {1'b0, !rd}, 1'b0} : 3'b001);
      tick();
      check({tag, "_en_E1"}, {ram_en, rom_en, ack}, 0);
      tick();
      check({tag, "_ack_E2"}, ack, 1);
      if (rd) check({tag, "_rdata"}, rdata, exp);
      finish_txn();
   endtask
   task automatic axi_read(input string tag, input logic [31:0] a, input logic [31:0] d, input logic [1:0] resp,
                           input logic [7:0] exp);
      start(AT_AXI, 1'b1, a, 0, 0, 0);
      check({tag, "_ar"}, {arvalid, araddr}, {1'b1, a});
      arready = 1'b1;
      tick();
      arready = 1'b0;
      check({tag, "_r"}, {arvalid, rready}, 2'b01);
      rvalid = 1'b1; rdata_axi = d; rresp = resp;
      tick();
      rvalid = 1'b0;
      check({tag, "_noack"}, ack, 0);
      tick();
      check({tag, "_done"}, {ack, err, rready, rdata}, {1'b1, resp != 2'd0, 1'b0, exp});
      finish_txn();
   endtask
   initial begin
      #12;
      check("reset_outs", {ack, err, rdata, led, awvalid, wvalid, bready, arvalid, rready, ram_en, rom_en}, 0);
      @(negedge clk);
      rst = 1'b0;
      tick();
      int_txn("ram_wr", AT_RAM, 1'b0, 32'h0000_1234, 8'h5A, 8'h00);
      int_txn("ram_rd", AT_RAM, 1'b1, 32'h0000_1234, 8'h00, 8'h5A);
      int_txn("rom_rd", AT_ROM, 1'b1, 32'h0000_0123, 8'h00, 8'h86);
      start(AT_AXI, 1'b0, UART_TX, 32'h41, 4'b0001, 8'h00);
      check("io_aw", {awvalid, wvalid, awaddr}, {2'b11, UART_TX});
      check("io_w", {wdata, wstrb_o}, {32'h41, 4'b0001});
      wready = 1'b1;
      tick();
      wready = 1'b0;
      check("io_w_drop", {awvalid, wvalid}, 2'b10);
      tick();
      tick();
      awready = 1'b1;
      tick();
      awready = 1'b0;
      check("io_aw_drop", {awvalid, wvalid, bready}, 3'b001);
      bvalid = 1'b1; bresp = 2'd0;
      tick();
      bvalid = 1'b0;
      check("io_noack", {ack, bready}, 0);
      tick();
      check("io_ack", {ack, err}, 2'b10);
      check("io_hs", {aw_hs[7:0], w_hs[7:0]}, 16'h0101);
      finish_txn();
      axi_read("axi_rd", 32'h2000_0002, 32'hAABB_CCDD, 2'd0, 8'hBB);
      axi_read("axi_rd_err", 32'h2000_0001, 32'h1122_3344, 2'd2, 8'h33);
      start(AT_AXI, 1'b0, 32'h3000_0003, 0, 4'b0000, 8'h77);
      check("mem_w", {wdata, wstrb_o}, {32'h7777_7777, 4'b1000});
      n = 0;
      while (!ack && n < T + 20) begin
         tick();
         n++;
      end
      check("to_cycles", n, T + 1);
      check("to_outs", {ack, err, rdata, awvalid, wvalid, bready, arvalid, rready}, {2'b11, 8'hFF, 5'b0});
      finish_txn();
      start(AT_LED, 1'b0, 32'h4000_0000, 0, 0, 8'h3C);
      check("led_wr", {led, err, ack}, {8'h3C, 2'b00});
      tick();
      check("led_ack", {ack, err}, 2'b10);
      finish_txn();
      start(AT_LED, 1'b1, 32'h4000_0000, 0, 0, 8'h00);
      tick();
      check("led_rd", {ack, rdata, led}, {1'b1, 8'h3C, 8'h3C});
      finish_txn();
      start(AT_UNK, 1'b1, 32'h5000_0000, 0, 0, 8'h00);
      check("unk_E0", ack, 0);
      tick();
      check("unk_E1", {ack, rdata}, {1'b1, 8'hFF});
      finish_txn();
      start(AT_NOP, 1'b1, 32'h0000_1234, 0, 0, 8'h00);
      tick();
      tick();
      check("nop_idle", {ack, ram_en, rom_en, awvalid, arvalid}, 0);
      req = 1'b0;
      tick();
      start(AT_AXI, 1'b1, 32'h2000_0000, 0, 0, 0);
      arready = 1'b1;
      tick();
      arready = 1'b0;
      check("rst_pre", rready, 1);
      #2;
      rst = 1'b1;
      #1;
      check("rst_async", {rready, arvalid, awvalid, wvalid, bready, ack, err}, 0);
      req = 1'b0;
      tick();
      rst = 1'b0;
      tick();
      int_txn("post_rst", AT_RAM, 1'b1, 32'h0000_1234, 8'h00, 8'h5A);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
